// File: rtl/btn_if.sv
// Button bundle between the pad-side driver and the conditioner.
// The master drives raw pad levels and enable; the slave returns clean levels and events.
interface btn_if #(
    parameter int N_BTN = 8
);
    logic [N_BTN-1:0] btn_raw;
    logic             en;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             press_valid;
    logic [2:0]       press_idx;
    logic             multi_press;

    modport master (
        output btn_raw, en,
        input  btn_level, btn_press, btn_release, press_valid, press_idx, multi_press
    );

    modport slave (
        input  btn_raw, en,
        output btn_level, btn_press, btn_release, press_valid, press_idx, multi_press
    );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronises and debounces raw pad buttons, emitting clean levels, one-cycle
// press/release pulses and an encoded lowest-index press for the game FSM.
module btn_conditioner #(
    parameter int N_BTN     = 8,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic  clk,
    input  logic  rst_n,
    btn_if.slave  btn
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_BTN-1:0]            sync1_q, sync2_q;
    logic [N_BTN-1:0]            level_q, level_d;
    logic [N_BTN-1:0]            press_q, press_d;
    logic [N_BTN-1:0]            release_q, release_d;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        valid_q, valid_d;
    logic                        multi_q, multi_d;
    logic [2:0]                  idx_q, idx_d;
    logic                        seen;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        level_d   = level_q;
        cnt_d     = cnt_q;
        press_d   = '0;
        release_d = '0;
        if (btn.en) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]   = sync2_q[i];
                    cnt_d[i]     = '0;
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        // Encoder looks at the next-state press vector so it lines up with btn_press.
        valid_d = |press_d;
        idx_d   = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_d[i]) idx_d = 3'(i);
        end
        multi_d = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (press_d[i]) begin
                if (seen) multi_d = 1'b1;
                seen = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            multi_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            // Synchroniser runs regardless of en so resumed counting sees fresh samples.
            sync1_q   <= btn.btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            multi_q   <= multi_d;
            idx_q     <= idx_d;
        end
    end

    assign btn.btn_level   = level_q;
    assign btn.btn_press   = press_q;
    assign btn.btn_release = release_q;
    assign btn.press_valid = valid_q;
    assign btn.press_idx   = idx_q;
    assign btn.multi_press = multi_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: a DB_CYCLES=4 instance for most scenarios
// and a default DB_CYCLES=16 instance for the long hold.
module tb_btn_conditioner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    btn_if #(.N_BTN(8)) bus4 ();
    btn_if #(.N_BTN(8)) bus16 ();

    btn_conditioner #(.N_BTN(8), .DB_CYCLES(4), .CNT_W(3)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus4.slave)
    );

    btn_conditioner #(.N_BTN(8), .DB_CYCLES(16), .CNT_W(5)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus16.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus4.btn_raw = '0;  bus4.en = 1'b1;
        bus16.btn_raw = '0; bus16.en = 1'b1;
        rst_n = 1'b0;
        #12;
        n_chk++; if (bus4.btn_level !== 8'h00) $display("FAIL rst_level: got %h want 00", bus4.btn_level); else n_pass++;
        n_chk++; if (bus4.btn_press !== 8'h00) $display("FAIL rst_press: got %h want 00", bus4.btn_press); else n_pass++;
        n_chk++; if (bus4.btn_release !== 8'h00) $display("FAIL rst_release: got %h want 00", bus4.btn_release); else n_pass++;
        n_chk++; if ({bus4.press_valid, bus4.press_idx, bus4.multi_press} !== 5'b0) $display("FAIL rst_encoder: got v%b i%0d m%b want all 0", bus4.press_valid, bus4.press_idx, bus4.multi_press); else n_pass++;
        n_chk++; if (bus16.btn_level !== 8'h00) $display("FAIL rst_level16: got %h want 00", bus16.btn_level); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Raw step first sampled at edge k: level and press appear after edge k+5 (DB=4).
    task automatic test_single_press();
        bus4.btn_raw = 8'h04;
        repeat (5) tick();
        n_chk++; if ({bus4.btn_level, bus4.btn_press} !== 16'h0000) $display("FAIL sp_early: got lvl %h prs %h want 00 00", bus4.btn_level, bus4.btn_press); else n_pass++;
        tick();
        n_chk++; if (bus4.btn_level !== 8'h04) $display("FAIL sp_level: got %h want 04", bus4.btn_level); else n_pass++;
        n_chk++; if (bus4.btn_press !== 8'h04) $display("FAIL sp_press: got %h want 04", bus4.btn_press); else n_pass++;
        n_chk++; if ({bus4.press_valid, bus4.press_idx, bus4.multi_press} !== {1'b1, 3'd2, 1'b0}) $display("FAIL sp_encoder: got v%b i%0d m%b want v1 i2 m0", bus4.press_valid, bus4.press_idx, bus4.multi_press); else n_pass++;
        tick();
        n_chk++; if ({bus4.btn_press, bus4.press_valid} !== 9'h0) $display("FAIL sp_pulse_end: got prs %h v%b want 00 v0", bus4.btn_press, bus4.press_valid); else n_pass++;
        n_chk++; if (bus4.btn_level !== 8'h04) $display("FAIL sp_level_hold: got %h want 04", bus4.btn_level); else n_pass++;
        bus4.btn_raw = 8'h00;
        repeat (5) tick();
        n_chk++; if ({bus4.btn_level, bus4.btn_release} !== 16'h0400) $display("FAIL sp_rel_early: got lvl %h rel %h want 04 00", bus4.btn_level, bus4.btn_release); else n_pass++;
        tick();
        n_chk++; if ({bus4.btn_level, bus4.btn_release, bus4.btn_press} !== 24'h000400) $display("FAIL sp_release: got lvl %h rel %h prs %h want 00 04 00", bus4.btn_level, bus4.btn_release, bus4.btn_press); else n_pass++;
        tick();
        n_chk++; if (bus4.btn_release !== 8'h00) $display("FAIL sp_rel_end: got %h want 00", bus4.btn_release); else n_pass++;
    endtask

    task automatic test_glitch();
        logic [3:0] pattern;
        pattern = 4'b0101;
        for (int i = 0; i < 14; i++) begin
            bus4.btn_raw = (i < 4) ? {7'b0, pattern[i]} : 8'h00;
            tick();
            n_chk++; if ({bus4.btn_level, bus4.btn_press, bus4.btn_release} !== 24'h0) $display("FAIL glitch_t%0d: got lvl %h prs %h rel %h want all 00", i, bus4.btn_level, bus4.btn_press, bus4.btn_release); else n_pass++;
        end
    endtask

    task automatic test_multi();
        bus4.btn_raw = 8'h24;
        repeat (5) tick();
        n_chk++; if (bus4.btn_press !== 8'h00) $display("FAIL mp_early: got %h want 00", bus4.btn_press); else n_pass++;
        tick();
        n_chk++; if (bus4.btn_press !== 8'h24) $display("FAIL mp_press: got %h want 24", bus4.btn_press); else n_pass++;
        n_chk++; if ({bus4.press_valid, bus4.press_idx, bus4.multi_press} !== {1'b1, 3'd2, 1'b1}) $display("FAIL mp_encoder: got v%b i%0d m%b want v1 i2 m1", bus4.press_valid, bus4.press_idx, bus4.multi_press); else n_pass++;
        tick();
        n_chk++; if ({bus4.btn_press, bus4.multi_press} !== 9'h0) $display("FAIL mp_pulse_end: got prs %h m%b want 00 m0", bus4.btn_press, bus4.multi_press); else n_pass++;
        bus4.btn_raw = 8'h00;
        repeat (5) tick();
        n_chk++; if (bus4.btn_release !== 8'h00) $display("FAIL mp_rel_early: got %h want 00", bus4.btn_release); else n_pass++;
        tick();
        n_chk++; if ({bus4.btn_release, bus4.btn_level, bus4.press_valid} !== {8'h24, 8'h00, 1'b0}) $display("FAIL mp_release: got rel %h lvl %h v%b want 24 00 v0", bus4.btn_release, bus4.btn_level, bus4.press_valid); else n_pass++;
        tick();
        n_chk++; if (bus4.btn_release !== 8'h00) $display("FAIL mp_rel_end: got %h want 00", bus4.btn_release); else n_pass++;
    endtask

    // Two stable sync2 samples leave the counter at 2; it then needs two en-high edges.
    task automatic test_enable();
        bus4.btn_raw = 8'h80;
        repeat (4) tick();
        bus4.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++; if ({bus4.btn_level, bus4.btn_press, bus4.btn_release, bus4.press_valid, bus4.press_idx, bus4.multi_press} !== 29'h0) $display("FAIL en_frozen_t%0d: got lvl %h prs %h rel %h v%b i%0d m%b want all 0", i, bus4.btn_level, bus4.btn_press, bus4.btn_release, bus4.press_valid, bus4.press_idx, bus4.multi_press); else n_pass++;
        end
        bus4.en = 1'b1;
        tick();
        n_chk++; if (bus4.btn_press !== 8'h00) $display("FAIL en_resume1: got %h want 00", bus4.btn_press); else n_pass++;
        tick();
        n_chk++; if ({bus4.btn_press, bus4.btn_level} !== 16'h8080) $display("FAIL en_resume2: got prs %h lvl %h want 80 80", bus4.btn_press, bus4.btn_level); else n_pass++;
        n_chk++; if ({bus4.press_valid, bus4.press_idx, bus4.multi_press} !== {1'b1, 3'd7, 1'b0}) $display("FAIL en_encoder: got v%b i%0d m%b want v1 i7 m0", bus4.press_valid, bus4.press_idx, bus4.multi_press); else n_pass++;
        tick();
        n_chk++; if (bus4.btn_press !== 8'h00) $display("FAIL en_pulse_end: got %h want 00", bus4.btn_press); else n_pass++;
        bus4.btn_raw = 8'h00;
        repeat (8) tick();
        n_chk++; if (bus4.btn_level !== 8'h00) $display("FAIL en_cleanup: got %h want 00", bus4.btn_level); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus4.btn_raw = 8'h01;
        repeat (6) tick();
        n_chk++; if ({bus4.btn_press, bus4.btn_level} !== 16'h0101) $display("FAIL rm_pre: got prs %h lvl %h want 01 01", bus4.btn_press, bus4.btn_level); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({bus4.btn_level, bus4.btn_press, bus4.btn_release, bus4.press_valid, bus4.press_idx, bus4.multi_press} !== 29'h0) $display("FAIL rm_async_clear: got lvl %h prs %h rel %h v%b i%0d m%b want all 0", bus4.btn_level, bus4.btn_press, bus4.btn_release, bus4.press_valid, bus4.press_idx, bus4.multi_press); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        n_chk++; if ({bus4.btn_press, bus4.btn_level} !== 16'h0000) $display("FAIL rm_early: got prs %h lvl %h want 00 00", bus4.btn_press, bus4.btn_level); else n_pass++;
        tick();
        n_chk++; if ({bus4.btn_press, bus4.press_valid, bus4.press_idx} !== {8'h01, 1'b1, 3'd0}) $display("FAIL rm_refire: got prs %h v%b i%0d want 01 v1 i0", bus4.btn_press, bus4.press_valid, bus4.press_idx); else n_pass++;
        tick();
        n_chk++; if (bus4.btn_press !== 8'h00) $display("FAIL rm_pulse_end: got %h want 00", bus4.btn_press); else n_pass++;
        bus4.btn_raw = 8'h00;
        repeat (8) tick();
    endtask

    // Raw high for edges 1..40: press after edge 18, release after edge 58.
    task automatic test_long_hold();
        int presses, releases, high, press_at, release_at;
        presses = 0; releases = 0; high = 0; press_at = -1; release_at = -1;
        bus16.btn_raw = 8'h01;
        for (int t = 1; t <= 80; t++) begin
            if (t == 41) bus16.btn_raw = 8'h00;
            tick();
            if (bus16.btn_press[0])   begin presses++;  press_at = t;   end
            if (bus16.btn_release[0]) begin releases++; release_at = t; end
            if (bus16.btn_level[0])   high++;
        end
        n_chk++; if (presses !== 1) $display("FAIL lh_press_count: got %0d want 1", presses); else n_pass++;
        n_chk++; if (releases !== 1) $display("FAIL lh_release_count: got %0d want 1", releases); else n_pass++;
        n_chk++; if (high !== 40) $display("FAIL lh_level_cycles: got %0d want 40", high); else n_pass++;
        n_chk++; if (press_at !== 18) $display("FAIL lh_press_edge: got %0d want 18", press_at); else n_pass++;
        n_chk++; if (release_at !== 58) $display("FAIL lh_release_edge: got %0d want 58", release_at); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_multi();
        test_enable();
        test_reset_mid();
        test_long_hold();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
